// File: rtl/csr_trap_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_if
// Purpose  : Commit-stage bundle between the decoder/commit logic and the
//            machine-mode CSR file / trap controller.
// Revision : 1.0 - initial release
// ============================================================================
interface csr_trap_if #(
    parameter int XLEN = 64
);
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [2:0]      exceptSignal;
    logic            trapReturn;
    logic            csrWriteEnable;
    logic [2:0]      funct3;
    logic [11:0]     csrAddr;
    logic [XLEN-1:0] csrWData;
    logic            srcIsZero;
    logic [XLEN-1:0] csrRData;
    logic [1:0]      privMode;
    logic            trapTaken;
    logic            redirect;
    logic [XLEN-1:0] redirectPC;

    // Commit side: presents the instruction, consumes the results
    modport master (
        output valid, pc, exceptSignal, trapReturn, csrWriteEnable,
               funct3, csrAddr, csrWData, srcIsZero,
        input  csrRData, privMode, trapTaken, redirect, redirectPC
    );

    // CSR/trap unit side
    modport slave (
        input  valid, pc, exceptSignal, trapReturn, csrWriteEnable,
               funct3, csrAddr, csrWData, srcIsZero,
        output csrRData, privMode, trapTaken, redirect, redirectPC
    );
endinterface
`default_nettype wire

// File: rtl/csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_unit
// Purpose  : Machine-mode CSR file and trap controller. Executes CSR
//            read/modify/write, synchronous exceptions and mret, owns the
//            privilege mode and drives the fetch redirect.
// Revision : 1.0 - initial release
// ============================================================================
module csr_trap_unit #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  wire logic clk,
    input  wire logic reset,
    csr_trap_if.slave bus
);

    localparam logic [11:0] c_addr_mstatus  = 12'h300;
    localparam logic [11:0] c_addr_misa     = 12'h301;
    localparam logic [11:0] c_addr_mtvec    = 12'h305;
    localparam logic [11:0] c_addr_mscratch = 12'h340;
    localparam logic [11:0] c_addr_mepc     = 12'h341;
    localparam logic [11:0] c_addr_mcause   = 12'h342;
    localparam logic [11:0] c_addr_mtval    = 12'h343;
    localparam logic [11:0] c_addr_mcycle   = 12'hB00;
    localparam logic [11:0] c_addr_minstret = 12'hB02;
    localparam logic [11:0] c_addr_mhartid  = 12'hF14;

    localparam logic [1:0]  c_priv_m = 2'b11;
    localparam logic [1:0]  c_priv_u = 2'b00;

    // MXL = 2 (64-bit), extensions I (bit 8) and U (bit 20)
    localparam logic [XLEN-1:0] c_misa = {2'b10, {(XLEN-2){1'b0}}}
                                       | (XLEN'(1) << 20)
                                       | (XLEN'(1) << 8);

    // Architectural state
    logic [1:0]      r_priv;
    logic            r_mie;
    logic            r_mpie;
    logic [1:0]      r_mpp;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic [XLEN-1:0] r_mcycle;
    logic [XLEN-1:0] r_minstret;

    logic [XLEN-1:0] w_rdata;
    logic            w_impl;
    logic            w_wr_attempt;
    logic [XLEN-1:0] w_new;
    logic            w_csr_illegal;
    logic            w_mret_illegal;
    logic            w_trap;
    logic            w_mret_ok;
    logic            w_csr_wr;
    logic [3:0]      w_cause;
    logic [XLEN-1:0] w_tval;

    // CSR read mux; also flags whether the address exists at all
    always_comb begin
        w_rdata = '0;
        w_impl  = 1'b1;
        case (bus.csrAddr)
            c_addr_mstatus: begin
                w_rdata[3]     = r_mie;
                w_rdata[7]     = r_mpie;
                w_rdata[12:11] = r_mpp;
            end
            c_addr_misa:     w_rdata = c_misa;
            c_addr_mtvec:    w_rdata = r_mtvec;
            c_addr_mscratch: w_rdata = r_mscratch;
            c_addr_mepc:     w_rdata = r_mepc;
            c_addr_mcause:   w_rdata = r_mcause;
            c_addr_mtval:    w_rdata = r_mtval;
            c_addr_mcycle:   w_rdata = r_mcycle;
            c_addr_minstret: w_rdata = r_minstret;
            c_addr_mhartid:  w_rdata = '0;
            default:         w_impl  = 1'b0;
        endcase
    end

    // Decode the CSR op (register and immediate forms alike) into a
    // write-attempt flag and the value that would be stored
    always_comb begin
        w_wr_attempt = 1'b0;
        w_new        = w_rdata;
        case (bus.funct3)
            3'b001, 3'b101: begin
                w_wr_attempt = 1'b1;
                w_new        = bus.csrWData;
            end
            3'b010, 3'b110: begin
                w_wr_attempt = ~bus.srcIsZero;
                w_new        = w_rdata | bus.csrWData;
            end
            3'b011, 3'b111: begin
                w_wr_attempt = ~bus.srcIsZero;
                w_new        = w_rdata & ~bus.csrWData;
            end
            default: ;
        endcase
    end

    // Trap cause selection: explicit exceptions first, highest bit wins,
    // anything else that traps is an illegal instruction
    always_comb begin
        w_cause = 4'd2;
        w_tval  = '0;
        if (bus.exceptSignal[2]) begin
            w_cause = 4'd2;
        end else if (bus.exceptSignal[1]) begin
            w_cause = (r_priv == c_priv_m) ? 4'd11 : 4'd8;
        end else if (bus.exceptSignal[0]) begin
            w_cause = 4'd3;
            w_tval  = bus.pc;
        end
    end

    assign w_csr_illegal  = bus.valid & bus.csrWriteEnable &
                            (~w_impl | (r_priv < bus.csrAddr[9:8]) |
                             (w_wr_attempt & (bus.csrAddr[11:10] == 2'b11)));
    assign w_mret_illegal = bus.valid & bus.trapReturn & (r_priv != c_priv_m);
    assign w_trap         = bus.valid & ((bus.exceptSignal != 3'b000) |
                                         w_csr_illegal | w_mret_illegal);
    assign w_mret_ok      = bus.valid & bus.trapReturn & ~w_trap;
    assign w_csr_wr       = bus.valid & bus.csrWriteEnable & w_wr_attempt &
                            ~w_trap & ~bus.trapReturn;

    assign bus.csrRData   = w_rdata;
    assign bus.privMode   = r_priv;
    assign bus.trapTaken  = w_trap;
    assign bus.redirect   = w_trap | w_mret_ok;
    assign bus.redirectPC = w_trap    ? r_mtvec :
                            w_mret_ok ? r_mepc  : '0;

    // State update: trap entry, mret, CSR write and the two counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_priv     <= c_priv_m;
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mpp      <= c_priv_u;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_trap) begin
                r_mepc   <= {bus.pc[XLEN-1:2], 2'b00};
                r_mcause <= XLEN'(w_cause);
                r_mtval  <= w_tval;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
                r_mpp    <= r_priv;
                r_priv   <= c_priv_m;
            end else if (w_mret_ok) begin
                r_priv   <= r_mpp;
                r_mie    <= r_mpie;
                r_mpie   <= 1'b1;
                r_mpp    <= c_priv_u;
            end else if (w_csr_wr) begin
                case (bus.csrAddr)
                    c_addr_mstatus: begin
                        r_mie  <= w_new[3];
                        r_mpie <= w_new[7];
                        // MPP holds only the modes this core supports
                        r_mpp  <= (w_new[12:11] == c_priv_m) ? c_priv_m : c_priv_u;
                    end
                    c_addr_mtvec:    r_mtvec    <= {w_new[XLEN-1:2], 2'b00};
                    c_addr_mscratch: r_mscratch <= w_new;
                    c_addr_mepc:     r_mepc     <= {w_new[XLEN-1:2], 2'b00};
                    c_addr_mcause:   r_mcause   <= w_new;
                    c_addr_mtval:    r_mtval    <= w_new;
                    default: ;
                endcase
            end

            // An explicit counter write replaces that cycle's increment
            if (w_csr_wr && bus.csrAddr == c_addr_mcycle)
                r_mcycle <= w_new;
            else
                r_mcycle <= r_mcycle + XLEN'(1);

            if (w_csr_wr && bus.csrAddr == c_addr_minstret)
                r_minstret <= w_new;
            else if (bus.valid && !w_trap)
                r_minstret <= r_minstret + XLEN'(1);
        end
    end

endmodule
`default_nettype wire
